// File: rtl/xadc_scan_ctrl.sv
// XADC DRP scan sequencer: round-robins the enabled VAUX channels, selecting each through
// CFG0, waiting out settling conversions, and banking the 12-bit result per channel.
module xadc_scan_ctrl #(
    parameter logic [10:0] CFG0_UPPER  = 11'h000,
    parameter int          DISCARD_EOC = 1,
    parameter int          DRP_TIMEOUT = 255,
    parameter int          EOC_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic [15:0] ch_mask,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    output logic [15:0] di_out,
    input  logic [15:0] do_in,
    input  logic        drdy_in,
    input  logic        eoc_in,
    output logic        res_valid,
    output logic [3:0]  res_ch,
    output logic [11:0] res_data,
    input  logic [3:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [3:0] {
        IDLE, PICK, WR_CFG, WAIT_WDRDY, SETTLE, WAIT_EOC, RD, WAIT_RDRDY, STORE
    } state_t;

    localparam logic [31:0] TMO_DRP   = 32'(DRP_TIMEOUT - 1);
    localparam logic [31:0] TMO_EOC   = 32'(EOC_TIMEOUT - 1);
    localparam logic [7:0]  DISC_INIT = 8'(DISCARD_EOC);

    state_t      state_r, state_next_s, cont_s;
    logic [3:0]  cur_ch_r, pick_ch_s, ch_sel_s;
    logic        pick_found_s, eoc_q_r, eoc_rise_s, timeout_s;
    logic [7:0]  disc_r;
    logic [31:0] tmr_r;
    logic [11:0] bank_r [16];
    logic        den_s, dwe_s, busy_s;
    logic [6:0]  daddr_s;
    logic [15:0] di_s;
    logic        unused_do_s;

    assign unused_do_s = ^do_in[3:0];
    assign eoc_rise_s  = eoc_in & ~eoc_q_r;
    assign cont_s      = (enable && (ch_mask != 16'h0000)) ? PICK : IDLE;
    assign ch_sel_s    = (state_r == PICK) ? pick_ch_s : cur_ch_r;
    assign rd_data     = bank_r[rd_ch];

    // Next enabled channel strictly after cur_ch; the 16th step lands back on cur_ch itself.
    always_comb begin
        logic [3:0] idx;
        pick_ch_s    = cur_ch_r;
        pick_found_s = 1'b0;
        idx          = 4'h0;
        for (int i = 1; i <= 16; i++) begin
            idx = cur_ch_r + 4'(i);
            if (!pick_found_s && ch_mask[idx]) begin
                pick_ch_s    = idx;
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a completed event always wins over a same-cycle timeout.
    always_comb begin
        state_next_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE:       state_next_s = cont_s;
            PICK:       state_next_s = pick_found_s ? WR_CFG : IDLE;
            WR_CFG:     state_next_s = WAIT_WDRDY;
            WAIT_WDRDY: begin
                if (drdy_in) begin
                    state_next_s = (DISCARD_EOC == 0) ? WAIT_EOC : SETTLE;
                end else if (tmr_r == TMO_DRP) begin
                    state_next_s = cont_s;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = WAIT_WDRDY;
                end
            end
            SETTLE: begin
                if (eoc_rise_s && (disc_r <= 8'd1)) begin
                    state_next_s = WAIT_EOC;
                end else if (tmr_r == TMO_EOC) begin
                    state_next_s = cont_s;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = SETTLE;
                end
            end
            WAIT_EOC: begin
                if (eoc_rise_s) begin
                    state_next_s = RD;
                end else if (tmr_r == TMO_EOC) begin
                    state_next_s = cont_s;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = WAIT_EOC;
                end
            end
            RD:         state_next_s = WAIT_RDRDY;
            WAIT_RDRDY: begin
                if (drdy_in) begin
                    state_next_s = STORE;
                end else if (tmr_r == TMO_DRP) begin
                    state_next_s = cont_s;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = WAIT_RDRDY;
                end
            end
            STORE:      state_next_s = cont_s;
            default:    state_next_s = IDLE;
        endcase
    end

    // Output decode from the next state so the registered DRP strobes line up with their states.
    always_comb begin
        den_s   = 1'b0;
        dwe_s   = 1'b0;
        daddr_s = 7'h00;
        di_s    = 16'h0000;
        busy_s  = (state_next_s != IDLE);
        case (state_next_s)
            WR_CFG: begin
                den_s   = 1'b1;
                dwe_s   = 1'b1;
                daddr_s = 7'h40;
                di_s    = {CFG0_UPPER, 5'h10 + {1'b0, ch_sel_s}};
            end
            RD: begin
                den_s   = 1'b1;
                daddr_s = 7'h10 + {3'b000, ch_sel_s};
            end
            default: begin
                den_s = 1'b0;
            end
        endcase
    end

    // Datapath, counters, result bank and registered outputs.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cur_ch_r    <= 4'h0;
            eoc_q_r     <= 1'b0;
            disc_r      <= 8'd0;
            tmr_r       <= 32'd0;
            den_out     <= 1'b0;
            dwe_out     <= 1'b0;
            daddr_out   <= 7'h00;
            di_out      <= 16'h0000;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= 4'h0;
            res_data    <= 12'h000;
            err_timeout <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                bank_r[i] <= 12'h000;
            end
        end else begin
            eoc_q_r   <= eoc_in;
            den_out   <= den_s;
            dwe_out   <= dwe_s;
            daddr_out <= daddr_s;
            di_out    <= di_s;
            busy      <= busy_s;
            res_valid <= (state_next_s == STORE);
            if (state_r == PICK && pick_found_s) begin
                cur_ch_r <= pick_ch_s;
            end
            if ((state_next_s != state_r) || (state_r == IDLE)) begin
                tmr_r <= 32'd0;
            end else begin
                tmr_r <= tmr_r + 32'd1;
            end
            if (state_r == WAIT_WDRDY && drdy_in) begin
                disc_r <= DISC_INIT;
            end else if (state_r == SETTLE && eoc_rise_s && disc_r != 8'd0) begin
                disc_r <= disc_r - 8'd1;
            end
            if (state_next_s == STORE) begin
                res_data <= do_in[15:4];
                res_ch   <= cur_ch_r;
            end
            if (state_r == STORE) begin
                bank_r[cur_ch_r] <= res_data;
            end
            if (timeout_s) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// Directed bench for xadc_scan_ctrl with a behavioural DRP responder and a periodic EOC source.
module tb_xadc_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] ch_mask = 16'h0000;
    logic [6:0]  daddr_out;
    logic        den_out, dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in = 16'h0000;
    logic        drdy_in = 1'b0;
    logic        eoc_in = 1'b0;
    logic        res_valid;
    logic [3:0]  res_ch;
    logic [11:0] res_data;
    logic [3:0]  rd_ch = 4'h0;
    logic [11:0] rd_data;
    logic        busy, err_timeout;

    int n_pass = 0, n_fail = 0, n_chk = 0;
    int drdy_delay = 3;
    int eoc_period = 100;
    bit drdy_mute = 1'b0;
    logic [15:0] rval [16];

    xadc_scan_ctrl #(.CFG0_UPPER(11'h000), .DISCARD_EOC(1), .DRP_TIMEOUT(20), .EOC_TIMEOUT(400)) dut (
        .clk(clk), .reset_p(reset_p), .enable(enable), .ch_mask(ch_mask),
        .daddr_out(daddr_out), .den_out(den_out), .dwe_out(dwe_out), .di_out(di_out),
        .do_in(do_in), .drdy_in(drdy_in), .eoc_in(eoc_in),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // DRP responder: answers each den_out after drdy_delay cycles, reads return rval[addr[3:0]].
    int dcnt = 0;
    bit dpend = 1'b0;
    logic [6:0] daddr_q = 7'h00;
    bit dwe_q = 1'b0;
    always begin
        @(posedge clk); #1;
        drdy_in = 1'b0;
        if (dpend) begin
            dcnt--;
            if (dcnt == 0) begin
                drdy_in = 1'b1;
                do_in   = dwe_q ? 16'h0000 : rval[daddr_q[3:0]];
                dpend   = 1'b0;
            end
        end
        if (den_out && !drdy_mute) begin
            dpend   = 1'b1;
            dcnt    = drdy_delay;
            daddr_q = daddr_out;
            dwe_q   = dwe_out;
        end
    end

    // EOC source: conversion restarts on every DRP write, then one pulse per eoc_period cycles.
    int ecnt = 0;
    always begin
        @(posedge clk); #1;
        if (den_out && dwe_out) ecnt = 0;
        else ecnt = (ecnt == eoc_period) ? 1 : ecnt + 1;
        eoc_in = (ecnt == eoc_period);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_den(input bit want_we, input int maxc, output bit ok, output int eocs);
        ok = 1'b0;
        eocs = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (den_out && (dwe_out == want_we)) begin
                ok = 1'b1;
                break;
            end
            if (eoc_in) eocs++;
        end
    endtask

    task automatic wait_res(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int ne, cyc, nrv, nden;
        logic [3:0] order [4];
        logic [3:0] rb [4];
        logic [11:0] rbx [4];
        order = '{4'd2, 4'd15, 4'd0, 4'd2};
        rb    = '{4'd0, 4'd2, 4'd15, 4'd1};
        for (int i = 0; i < 16; i++) rval[i] = {4'(i), 4'hA, 4'(15 - i), 4'h0};
        rval[6] = 16'hABC0;
        rbx = '{rval[0][15:4], rval[2][15:4], rval[15][15:4], 12'h000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, den_out, dwe_out, res_valid, err_timeout, res_ch, res_data, daddr_out}, 32'h0);
        chk("rst_di", di_out, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        reset_p = 1'b0;
        @(negedge clk);

        // Single channel 6
        ch_mask = 16'h0040;
        enable  = 1'b1;
        wait_den(1'b1, 20, ok, ne);
        chk("t1_wr_seen", ok, 1);
        chk("t1_wr_addr", daddr_out, 32'h40);
        chk("t1_wr_di", di_out, 32'h0016);
        wait_den(1'b0, 400, ok, ne);
        chk("t1_rd_seen", ok, 1);
        chk("t1_rd_addr", daddr_out, 32'h16);
        chk("t1_eoc_count", ne, 2);
        wait_res(20, ok);
        chk("t1_res_seen", ok, 1);
        chk("t1_res_ch", res_ch, 6);
        chk("t1_res_data", res_data, 32'hABC);
        rd_ch = 4'd6;
        @(negedge clk);
        chk("t1_bank6", rd_data, 32'hABC);
        wait_res(400, ok);
        chk("t1_repeat_seen", ok, 1);
        chk("t1_repeat_ch", res_ch, 6);
        enable = 1'b0;
        wait_idle(500, ok);
        chk("t1_idle", ok, 1);

        // Round-robin over 16'h8005 from reset
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        ch_mask = 16'h8005;
        enable  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_res(500, ok);
            chk("t2_res_seen", ok, 1);
            chk("t2_res_ch", res_ch, order[k]);
            chk("t2_res_data", res_data, rval[order[k]][15:4]);
        end
        enable = 1'b0;
        wait_idle(500, ok);
        chk("t2_idle", ok, 1);
        for (int k = 0; k < 4; k++) begin
            rd_ch = rb[k];
            #1;
            chk("t2_bank", rd_data, rbx[k]);
        end

        // Write timeout on channel 4, then channel 5 completes
        drdy_mute = 1'b1;
        ch_mask   = 16'h0030;
        enable    = 1'b1;
        wait_den(1'b1, 20, ok, ne);
        chk("t3_wr_seen", ok, 1);
        chk("t3_wr_di", di_out, 32'h0014);
        cyc = 0;
        nrv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (res_valid) nrv++;
            if (err_timeout) break;
        end
        chk("t3_err_latency", cyc, 21);
        chk("t3_no_res", nrv, 0);
        drdy_mute = 1'b0;
        wait_den(1'b1, 20, ok, ne);
        chk("t3_next_di", di_out, 32'h0015);
        wait_res(500, ok);
        chk("t3_res_ch", res_ch, 5);
        chk("t3_err_sticky", err_timeout, 1);
        rd_ch = 4'd4;
        #1;
        chk("t3_bank4_unchanged", rd_data, 32'h0);

        // Enable drop while waiting for the accepted conversion on channel 4
        wait_den(1'b1, 20, ok, ne);
        chk("t4_wr_di", di_out, 32'h0014);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (eoc_in) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_first_eoc", ok, 1);
        @(negedge clk);
        enable = 1'b0;
        wait_res(300, ok);
        chk("t4_res_seen", ok, 1);
        chk("t4_res_ch", res_ch, 4);
        chk("t4_res_data", res_data, rval[4][15:4]);
        @(negedge clk);
        chk("t4_busy_fall", busy, 0);
        nden = 0;
        nrv  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (den_out) nden++;
            if (res_valid) nrv++;
        end
        chk("t4_no_den", nden, 0);
        chk("t4_no_res", nrv, 0);

        // Mask change while channel 0 settles
        ch_mask = 16'h0001;
        enable  = 1'b1;
        wait_den(1'b1, 20, ok, ne);
        chk("t5_wr_di", di_out, 32'h0010);
        repeat (10) @(negedge clk);
        ch_mask = 16'h0010;
        wait_res(400, ok);
        chk("t5_res_ch", res_ch, 0);
        chk("t5_res_data", res_data, rval[0][15:4]);
        wait_den(1'b1, 20, ok, ne);
        chk("t5_next_di", di_out, 32'h0014);

        // Reset during the read of channel 4, late drdy afterwards
        wait_den(1'b0, 400, ok, ne);
        chk("t6_rd_addr", daddr_out, 32'h14);
        @(negedge clk);
        reset_p = 1'b1;
        enable  = 1'b0;
        #1;
        chk("t6_rst_outs", {busy, den_out, dwe_out, res_valid, err_timeout, res_ch, res_data, daddr_out}, 32'h0);
        @(negedge clk);
        reset_p = 1'b0;
        nrv = 0;
        nden = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) nrv++;
            if (busy || den_out) nden++;
        end
        chk("t6_no_res", nrv, 0);
        chk("t6_stays_idle", nden, 0);
        rd_ch = 4'd4;
        #1;
        chk("t6_bank4", rd_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
